// File: rtl/vending_coin_payer.sv
// Coin payer: pays a fixed PRICE from a two-denomination wallet (0.5 and 1.0 coins).
// It inserts coins greedily, then waits for the machine's sell/change handshake.
module vending_coin_payer #(
  parameter int PRICE   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       load,
  input  logic [3:0] load_n05,
  input  logic [3:0] load_n10,
  input  logic       sell,
  input  logic [1:0] change,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] n05,
  output logic [3:0] n10
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INSERT    = 3'd1,
    GAP       = 3'd2,
    WAIT_SELL = 3'd3,
    DONE      = 3'd4,
    ERR       = 3'd5
  } state_t;

  localparam logic [3:0] PRICE_L      = 4'(PRICE);
  localparam logic [5:0] PRICE_W      = 6'(PRICE);
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_05   = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

  state_t     state, state_nxt;
  logic [3:0] remaining, rem_nxt;
  logic       expect_change, exp_nxt;
  logic [3:0] tcnt, tcnt_nxt;
  logic [1:0] coin_nxt;
  logic [3:0] n05_nxt, n10_nxt;
  logic [5:0] funds;

  logic [3:0] rem_src;
  logic [1:0] ins_coin;
  logic [3:0] ins_rem, ins_n05, ins_n10;
  logic       ins_over;

  assign funds = {2'b00, n05} + {1'b0, n10, 1'b0};

  // The coin is chosen on the edge that enters INSERT so the registered coin is
  // visible for the whole INSERT cycle; from IDLE the balance starts at PRICE.
  always_comb begin
    rem_src  = (state == IDLE) ? PRICE_L : remaining;
    ins_coin = COIN_10;
    ins_rem  = 4'd0;
    ins_n05  = n05;
    ins_n10  = n10;
    ins_over = 1'b0;
    if (rem_src >= 4'd2 && n10 != 4'd0) begin
      ins_n10 = n10 - 4'd1;
      ins_rem = rem_src - 4'd2;
    end else if (n05 != 4'd0) begin
      ins_coin = COIN_05;
      ins_n05  = n05 - 4'd1;
      ins_rem  = rem_src - 4'd1;
    end else begin
      ins_over = 1'b1;
      if (n10 != 4'd0) ins_n10 = n10 - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    exp_nxt   = expect_change;
    tcnt_nxt  = tcnt;
    coin_nxt  = COIN_NONE;
    n05_nxt   = n05;
    n10_nxt   = n10;
    case (state)
      IDLE: begin
        if (start) begin
          exp_nxt = 1'b0;
          if (funds < PRICE_W) begin
            state_nxt = ERR;
          end else begin
            state_nxt = INSERT;
            coin_nxt  = ins_coin;
            rem_nxt   = ins_rem;
            exp_nxt   = ins_over;
            n05_nxt   = ins_n05;
            n10_nxt   = ins_n10;
          end
        end else if (load) begin
          n05_nxt = load_n05;
          n10_nxt = load_n10;
        end
      end
      INSERT: state_nxt = GAP;
      GAP: begin
        if (remaining == 4'd0) begin
          state_nxt = WAIT_SELL;
          tcnt_nxt  = 4'd0;
        end else begin
          state_nxt = INSERT;
          coin_nxt  = ins_coin;
          rem_nxt   = ins_rem;
          exp_nxt   = expect_change | ins_over;
          n05_nxt   = ins_n05;
          n10_nxt   = ins_n10;
        end
      end
      WAIT_SELL: begin
        if (sell) begin
          if (change == COIN_05 && expect_change) begin
            state_nxt = DONE;
            n05_nxt   = sat_inc(n05);
          end else if (change == COIN_NONE && !expect_change) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ERR;
          end
        end else if (tcnt == TIMEOUT_LAST) begin
          state_nxt = ERR;
        end else begin
          tcnt_nxt = tcnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      coin          <= COIN_NONE;
      remaining     <= 4'd0;
      expect_change <= 1'b0;
      tcnt          <= 4'd0;
      n05           <= 4'd0;
      n10           <= 4'd0;
    end else begin
      state         <= state_nxt;
      coin          <= coin_nxt;
      remaining     <= rem_nxt;
      expect_change <= exp_nxt;
      tcnt          <= tcnt_nxt;
      n05           <= n05_nxt;
      n10           <= n10_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == ERR);

endmodule

// File: tb/tb_vending_coin_payer.sv
// Bench for vending_coin_payer: two instances (PRICE 4 and 3) driven by directed
// and randomized purchases, checked against a transaction-level wallet model.
module tb_vending_coin_payer;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] start_v, load_v, sell_v;
  logic [3:0] ld05, ld10;
  logic [1:0] chg;
  logic [1:0] coin_v [2];
  logic [1:0] busy_v, done_v, err_v;
  logic [3:0] n05_v [2];
  logic [3:0] n10_v [2];

  int price [2] = '{4, 3};
  int m05 [2];
  int m10 [2];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vending_coin_payer #(.PRICE(4), .TIMEOUT(TO)) u_dut4 (
    .clk(clk), .rstn(rstn), .start(start_v[0]), .load(load_v[0]),
    .load_n05(ld05), .load_n10(ld10), .sell(sell_v[0]), .change(chg),
    .coin(coin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .n05(n05_v[0]), .n10(n10_v[0])
  );

  vending_coin_payer #(.PRICE(3), .TIMEOUT(TO)) u_dut3 (
    .clk(clk), .rstn(rstn), .start(start_v[1]), .load(load_v[1]),
    .load_n05(ld05), .load_n10(ld10), .sell(sell_v[1]), .change(chg),
    .coin(coin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .n05(n05_v[1]), .n10(n10_v[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string tag);
    check_val($sformatf("%s d%0d busy", tag, d), busy_v[d], 0);
    check_val($sformatf("%s d%0d done", tag, d), done_v[d], 0);
    check_val($sformatf("%s d%0d err", tag, d), err_v[d], 0);
    check_val($sformatf("%s d%0d coin", tag, d), coin_v[d], 0);
    check_val($sformatf("%s d%0d n05", tag, d), n05_v[d], m05[d]);
    check_val($sformatf("%s d%0d n10", tag, d), n10_v[d], m10[d]);
  endtask

  task automatic do_load(input int d, input int a05, input int a10);
    ld05 = 4'(a05);
    ld10 = 4'(a10);
    load_v[d] = 1'b1;
    cyc();
    load_v[d] = 1'b0;
    m05[d] = a05;
    m10[d] = a10;
    check_idle(d, "load");
  endtask

  // sell_at >= TO means sell is never asserted in WAIT_SELL
  task automatic purchase(input int d, input int sell_at, input logic [1:0] c, input bit noise);
    int  e05, e10, rem, k, ws, end_t, exp_coin;
    bit  over, fail_now, exp_done;
    int  coins[$];
    e05 = m05[d];
    e10 = m10[d];
    rem = price[d];
    over = 1'b0;
    fail_now = (e05 + 2 * e10) < price[d];
    if (!fail_now) begin
      while (rem > 0) begin
        if (rem >= 2 && e10 > 0) begin
          coins.push_back(2); e10--; rem -= 2;
        end else if (e05 > 0) begin
          coins.push_back(1); e05--; rem -= 1;
        end else begin
          coins.push_back(2); e10--; rem = 0; over = 1'b1;
        end
      end
    end
    k  = coins.size();
    ws = 2 * k + 1;
    if (fail_now) begin
      end_t = 1; exp_done = 1'b0;
    end else if (sell_at < TO) begin
      end_t = ws + sell_at + 1;
      exp_done = (c == 2'b01 && over) || (c == 2'b00 && !over);
      if (exp_done && c == 2'b01) e05 = (e05 == 15) ? 15 : e05 + 1;
    end else begin
      end_t = ws + TO; exp_done = 1'b0;
    end

    chg = c;
    start_v[d] = 1'b1;
    if (noise) begin
      load_v[d] = 1'b1;
      ld05 = 4'($urandom_range(0, 15));
      ld10 = 4'($urandom_range(0, 15));
    end
    for (int t = 1; t <= end_t; t++) begin
      cyc();
      exp_coin = (!fail_now && t <= 2 * k && (t % 2) == 1) ? coins[(t - 1) / 2] : 0;
      check_val($sformatf("d%0d coin t%0d", d, t), coin_v[d], exp_coin);
      check_val($sformatf("d%0d busy t%0d", d, t), busy_v[d], 1);
      check_val($sformatf("d%0d done t%0d", d, t), done_v[d], (t == end_t) && exp_done);
      check_val($sformatf("d%0d err t%0d", d, t), err_v[d], (t == end_t) && !exp_done);
      if (noise && t < end_t) begin
        start_v[d] = 1'($urandom_range(0, 1));
        load_v[d]  = 1'($urandom_range(0, 1));
        ld05 = 4'($urandom_range(0, 15));
        ld10 = 4'($urandom_range(0, 15));
      end else begin
        start_v[d] = 1'b0;
        load_v[d]  = 1'b0;
      end
      if (!fail_now && t == ws + sell_at) sell_v[d] = 1'b1;
      else if (noise && t < end_t && (fail_now || t < ws)) sell_v[d] = 1'($urandom_range(0, 1));
      else sell_v[d] = 1'b0;
      if (t == end_t) sell_v[d] = 1'b0;
    end
    cyc();
    m05[d] = e05;
    m10[d] = e10;
    check_idle(d, "after");
  endtask

  task automatic reset_mid_insert();
    do_load(0, 3, 3);
    start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    check_val("rst pre coin", coin_v[0], 2);
    #2 rstn = 1'b0;
    #1;
    check_val("rst coin async", coin_v[0], 0);
    check_val("rst busy", busy_v[0], 0);
    m05[0] = 0; m10[0] = 0; m05[1] = 0; m10[1] = 0;
    #2 rstn = 1'b1;
    cyc();
    check_idle(0, "rst");
    check_idle(1, "rst");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d, sa;
    logic [1:0] c;
    rstn = 1'b0;
    start_v = '0; load_v = '0; sell_v = '0;
    ld05 = '0; ld10 = '0; chg = '0;
    m05 = '{0, 0}; m10 = '{0, 0};
    #12;
    check_idle(0, "reset");
    check_idle(1, "reset");
    rstn = 1'b1;
    cyc();

    do_load(0, 0, 2);  purchase(0, 3, 2'b00, 1'b0);
    do_load(0, 4, 0);  purchase(0, 0, 2'b00, 1'b0);
    do_load(1, 1, 2);  purchase(1, 1, 2'b00, 1'b0);
    do_load(1, 0, 2);  purchase(1, 2, 2'b01, 1'b0);
    do_load(1, 0, 2);  purchase(1, 2, 2'b00, 1'b0);
    do_load(0, 1, 1);  purchase(0, 0, 2'b00, 1'b0);
    do_load(0, 0, 2);  purchase(0, TO, 2'b00, 1'b1);
    do_load(0, 15, 0); purchase(0, TO - 1, 2'b00, 1'b1);
    reset_mid_insert();

    for (int i = 0; i < 60; i++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 2) != 0) do_load(d, $urandom_range(0, 6), $urandom_range(0, 4));
      sa = $urandom_range(0, TO + 1);
      case ($urandom_range(0, 5))
        0, 1:    c = 2'b00;
        2, 3:    c = 2'b01;
        4:       c = 2'b10;
        default: c = 2'b11;
      endcase
      purchase(d, sa, c, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
